// File: rtl/reg_status_file_pkg.sv
// Shared sizing for the architectural register file with rename status.
package reg_status_file_pkg;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned IDX_W     = $clog2(REG_NUM);
  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);
endpackage

// File: rtl/rf_read_port.sv
// One combinational operand read port over the register/status tables.
// Optional same-cycle commit forwarding when RF_COMMIT_BYPASS_EN is defined.
module rf_read_port
  import reg_status_file_pkg::*;
(
  input  logic [IDX_W-1:0] id,
  input  logic [XLEN-1:0]  val_tbl [REG_NUM],
  input  logic [REG_NUM-1:0] busy_tbl,
  input  logic [TAG_W-1:0] tag_tbl [REG_NUM],
  input  logic             commit_en,
  input  logic [IDX_W-1:0] commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_val,
  output logic [XLEN-1:0]  val,
  output logic             busy,
  output logic [TAG_W-1:0] tag
);

  always_comb begin
    val  = val_tbl[id];
    busy = busy_tbl[id];
    tag  = tag_tbl[id];
    if (id == '0) begin
      val  = '0;
      busy = 1'b0;
      tag  = '0;
    end
`ifdef RF_COMMIT_BYPASS_EN
    // Only the pending producer's own commit may be forwarded.
    else if (commit_en && commit_rd == id && busy_tbl[id] && tag_tbl[id] == commit_tag) begin
      val  = commit_val;
      busy = 1'b0;
    end
`endif
  end

`ifdef RF_COMMIT_BYPASS_EN
`else
  logic unused_commit;
  assign unused_commit = ^{commit_en, commit_rd, commit_tag, commit_val};
`endif

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename busy/tag, fed by dispatch and ROB commit.
// Build option: RF_COMMIT_BYPASS_EN enables same-cycle commit forwarding on the read ports.
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             issue_en,
  input  logic [IDX_W-1:0] issue_rd,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [IDX_W-1:0] rs1_id,
  input  logic [IDX_W-1:0] rs2_id,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [TAG_W-1:0] rs1_tag,
  output logic [TAG_W-1:0] rs2_tag,
  input  logic             commit_en,
  input  logic [IDX_W-1:0] commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_val
);

  logic [XLEN-1:0]    val_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [TAG_W-1:0]   tag_q [REG_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '{default: '0};
      busy_q <= '0;
      tag_q  <= '{default: '0};
    end else if (rdy) begin
      if (commit_en && commit_rd != '0) begin
        val_q[commit_rd] <= commit_val;
        // A stale commit (newer producer pending) leaves the rename intact.
        if (busy_q[commit_rd] && tag_q[commit_rd] == commit_tag) begin
          busy_q[commit_rd] <= 1'b0;
        end
      end
      // Later assignments win: clear beats both, issue beats commit release.
      if (clear) begin
        busy_q <= '0;
      end else if (issue_en && issue_rd != '0) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_tag;
      end
    end
  end

  rf_read_port u_rs1 (
    .id         (rs1_id),
    .val_tbl    (val_q),
    .busy_tbl   (busy_q),
    .tag_tbl    (tag_q),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .val        (rs1_val),
    .busy       (rs1_busy),
    .tag        (rs1_tag)
  );

  rf_read_port u_rs2 (
    .id         (rs2_id),
    .val_tbl    (val_q),
    .busy_tbl   (busy_q),
    .tag_tbl    (tag_q),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val),
    .val        (rs2_val),
    .busy       (rs2_busy),
    .tag        (rs2_tag)
  );

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench: directed scenarios plus randomized traffic against a rule-level model.
module tb_reg_status_file;
  import reg_status_file_pkg::*;

  logic             clk = 1'b0;
  logic             rst, rdy, clear, issue_en, commit_en;
  logic [IDX_W-1:0] issue_rd, rs1_id, rs2_id, commit_rd;
  logic [TAG_W-1:0] issue_tag, commit_tag, rs1_tag, rs2_tag;
  logic [XLEN-1:0]  rs1_val, rs2_val, commit_val;
  logic             rs1_busy, rs2_busy;

  int checks = 0;
  int failures = 0;

  // Reference state: what each architectural register holds and who will produce it.
  logic [XLEN-1:0]  m_val  [REG_NUM];
  bit               m_busy [REG_NUM];
  logic [TAG_W-1:0] m_tag  [REG_NUM];

  always #5 clk = ~clk;

  reg_status_file dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .issue_en   (issue_en),
    .issue_rd   (issue_rd),
    .issue_tag  (issue_tag),
    .rs1_id     (rs1_id),
    .rs2_id     (rs2_id),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rs1_tag    (rs1_tag),
    .rs2_tag    (rs2_tag),
    .commit_en  (commit_en),
    .commit_rd  (commit_rd),
    .commit_tag (commit_tag),
    .commit_val (commit_val)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; clear = 1'b0;
    issue_en = 1'b0; issue_rd = '0; issue_tag = '0;
    commit_en = 1'b0; commit_rd = '0; commit_tag = '0; commit_val = '0;
  endtask

  // Apply the architectural rules for one clock edge, using the inputs held during the cycle.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy) begin
      bit release_it;
      release_it = commit_en && commit_rd != 0 && m_busy[commit_rd] && m_tag[commit_rd] == commit_tag;
      if (commit_en && commit_rd != 0) m_val[commit_rd] = commit_val;
      if (release_it) m_busy[commit_rd] = 1'b0;
      if (clear) begin
        for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
      end else if (issue_en && issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_tag;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check_port(input string nm, input logic [IDX_W-1:0] id,
                            input logic [XLEN-1:0] v, input logic b, input logic [TAG_W-1:0] t);
    logic [XLEN-1:0]  ev;
    logic             eb;
    logic [TAG_W-1:0] et;
    if (id == 0) begin
      ev = '0; eb = 1'b0; et = '0;
    end else begin
      ev = m_val[id]; eb = m_busy[id]; et = m_tag[id];
`ifdef RF_COMMIT_BYPASS_EN
      if (commit_en && commit_rd == id && m_busy[id] && m_tag[id] == commit_tag) begin
        ev = commit_val; eb = 1'b0;
      end
`endif
    end
    check({nm, "_busy"}, 32'(b), 32'(eb));
    if (eb) check({nm, "_tag"}, 32'(t), 32'(et));
    else    check({nm, "_val"}, v, ev);
  endtask

  task automatic rd_chk(input string nm, input int id, input logic [31:0] v,
                        input logic b, input logic [TAG_W-1:0] t);
    rs1_id = IDX_W'(id); rs2_id = IDX_W'(id);
    #1;
    check({nm, "_rs1_val"},  rs1_val, v);
    check({nm, "_rs1_busy"}, 32'(rs1_busy), 32'(b));
    check({nm, "_rs1_tag"},  32'(rs1_tag), 32'(t));
    check({nm, "_rs2_val"},  rs2_val, v);
    check({nm, "_rs2_busy"}, 32'(rs2_busy), 32'(b));
  endtask

  initial begin
    idle();
    rs1_id = '0; rs2_id = '0;
    rst = 1'b1;
    @(negedge clk);
    tick(); tick();
    idle();

    rd_chk("reset_x5", 5, 0, 0, 0);
    issue_en = 1; issue_rd = 0; issue_tag = 3; tick(); idle();
    rd_chk("x0_issue", 0, 0, 0, 0);

    issue_en = 1; issue_rd = 5; issue_tag = 3; tick(); idle();
    rd_chk("x5_pending", 5, 0, 1, 3);
    commit_en = 1; commit_rd = 5; commit_tag = 3; commit_val = 32'hDEAD; tick(); idle();
    rd_chk("x5_commit", 5, 32'hDEAD, 0, 3);

    issue_en = 1; issue_rd = 5; issue_tag = 3; tick();
    issue_tag = 7; tick(); idle();
    commit_en = 1; commit_rd = 5; commit_tag = 3; commit_val = 32'h11; tick(); idle();
    rd_chk("x5_stale", 5, 32'h11, 1, 7);
    commit_en = 1; commit_rd = 5; commit_tag = 7; commit_val = 32'h22; tick(); idle();
    rd_chk("x5_latest", 5, 32'h22, 0, 7);

    issue_en = 1; issue_rd = 6; issue_tag = 2; tick(); idle();
    issue_en = 1; issue_rd = 6; issue_tag = 9;
    commit_en = 1; commit_rd = 6; commit_tag = 2; commit_val = 32'h55; tick(); idle();
    rd_chk("x6_same_cyc", 6, 32'h55, 1, 9);

    for (int r = 1; r <= 4; r++) begin
      issue_en = 1; issue_rd = IDX_W'(r); issue_tag = TAG_W'(r); tick();
    end
    idle();
    rdy = 0; clear = 1; commit_en = 1; commit_rd = 2; commit_val = 32'h77; commit_tag = 0;
    issue_en = 1; issue_rd = 8; issue_tag = 5; tick();
    rdy = 0; clear = 0; commit_en = 0; issue_en = 0;
    rd_chk("frozen_x2", 2, 0, 1, 2);
    rd_chk("frozen_x8", 8, 0, 0, 0);
    rdy = 1; clear = 1; commit_en = 1; commit_rd = 2; commit_val = 32'h77; commit_tag = 0;
    issue_en = 1; issue_rd = 8; issue_tag = 5; tick(); idle();
    rd_chk("clear_x1", 1, 0, 0, 1);
    rd_chk("clear_x2", 2, 32'h77, 0, 2);
    rd_chk("clear_x4", 4, 0, 0, 4);
    rd_chk("clear_x8", 8, 0, 0, 0);

    issue_en = 1; issue_rd = 7; issue_tag = 4; tick(); idle();
    commit_en = 1; commit_rd = 7; commit_tag = 4; commit_val = 32'h99;
    rs1_id = 7; rs2_id = 7;
    #1;
`ifdef RF_COMMIT_BYPASS_EN
    check("bypass_busy", 32'(rs1_busy), 0);
    check("bypass_val", rs1_val, 32'h99);
    check("bypass_busy2", 32'(rs2_busy), 0);
`else
    check("nobypass_busy", 32'(rs1_busy), 1);
    check("nobypass_tag", 32'(rs1_tag), 4);
    check("nobypass_busy2", 32'(rs2_busy), 1);
`endif
    tick(); idle();
    rd_chk("x7_after", 7, 32'h99, 0, 4);

    // Randomized traffic on a narrow register window so renames and commits collide.
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      rdy        = ($urandom_range(0, 9) != 0);
      clear      = ($urandom_range(0, 19) == 0);
      issue_en   = $urandom_range(0, 1) == 1;
      issue_rd   = IDX_W'($urandom_range(0, 7));
      issue_tag  = TAG_W'($urandom);
      commit_en  = $urandom_range(0, 1) == 1;
      commit_rd  = IDX_W'($urandom_range(0, 7));
      commit_tag = ($urandom_range(0, 9) < 6) ? m_tag[commit_rd] : TAG_W'($urandom);
      commit_val = $urandom;
      rs1_id     = IDX_W'($urandom_range(0, 7));
      rs2_id     = ($urandom_range(0, 1) == 1) ? commit_rd : IDX_W'($urandom_range(0, 31));
      #1;
      check_port("rand_rs1", rs1_id, rs1_val, rs1_busy, rs1_tag);
      check_port("rand_rs2", rs2_id, rs2_val, rs2_busy, rs2_tag);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
# reg_status_file

Architectural register file with per-register rename status, sitting between the dispatcher and the 16-entry reorder buffer. Dispatch reads operands from it and marks each new destination register with the ROB tag that will produce it. ROB commit writes the retired value back and releases the register once the committing tag matches the latest pending producer. A ROB flush drops every pending rename in one cycle while keeping committed values.

## Interface
- REG_NUM, 32, number of architectural registers; index 0 is hardwired zero
- XLEN, 32, data width
- TAG_W, 4, ROB tag width (16 ROB entries)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- clear  in  1  ROB flush; drop all pending renames
- issue_en  in  1  dispatch allocates a destination this cycle
- issue_rd  in  5  destination register of the dispatched instruction
- issue_tag  in  TAG_W  ROB entry allocated to it
- rs1_id, rs2_id  in  5 each  source register indices
- rs1_val, rs2_val  out  XLEN each  operand value (valid when busy low)
- rs1_busy, rs2_busy  out  1 each  operand still pending in the ROB
- rs1_tag, rs2_tag  out  TAG_W each  producing ROB tag (meaningful when busy high)
- commit_en  in  1  ROB retires an instruction this cycle
- commit_rd  in  5  retiring destination register
- commit_tag  in  TAG_W  retiring ROB entry
- commit_val  in  XLEN  retiring value

## Operation
- State per register: val[XLEN], busy, tag[TAG_W]
- Read ports are combinational from the current state. rsN_busy = busy[rsN_id], rsN_tag = tag[rsN_id], rsN_val = val[rsN_id]
- Register 0: reads always return val 0, busy 0, tag 0. Issue and commit to rd 0 are ignored
- Commit, when commit_en and rdy: val[commit_rd] <= commit_val. If busy[commit_rd] and tag[commit_rd]==commit_tag, then busy <= 0. A tag mismatch (a newer producer is pending) writes the value but leaves busy and tag unchanged
- Issue, when issue_en and rdy: busy[issue_rd] <= 1, tag[issue_rd] <= issue_tag. Rename is last-writer-wins
- Same cycle, issue and commit to the same rd: the value is written and issue wins busy/tag (busy stays 1 with the new tag)
- Reads in the issue cycle see the state before that issue, so "add x1,x1,x2" reads the old x1 status
- clear, when rdy: all busy <= 0. A simultaneous commit still writes its value. A simultaneous issue is discarded
- rdy low: no state change, including under clear/issue/commit
- rst: every val, busy and tag cleared to 0; it overrides rdy, clear, issue and commit

## Timing
- Reads: zero-cycle combinational
- Writes (commit value, busy/tag update): visible on reads the cycle after the clk edge
- Reset values: every register val 0, busy 0, tag 0, so all rsN_* outputs are 0 after reset
- clear takes effect at the next edge; the following cycle all busy are 0

## Configuration
- RF_COMMIT_BYPASS_EN defined: same-cycle forwarding on both read ports. If commit_en and commit_rd==rsN_id!=0 and busy[rsN_id] and tag[rsN_id]==commit_tag, the port returns rsN_val = commit_val and rsN_busy = 0 in that same cycle
- RF_COMMIT_BYPASS_EN undefined: no forwarding; the port reports busy with the tag, and the value is available one cycle later. The dispatcher catches it via the ROB commit broadcast
- State update behaviour is identical in both builds

## Structure
- Shared package/header: XLEN, TAG_W, REG_NUM, reg-index width, ROB depth
- One sub-module, rf_read_port: instantiated twice; combinational mux of state plus optional bypass under RF_COMMIT_BYPASS_EN

## Test plan
- Reset then read x5 -> val 0, busy 0, tag 0. Issue to x0 tag 3 then read x0 -> busy 0, val 0
- Issue x5 tag 3; next cycle read x5 -> busy 1, tag 3. Commit x5 tag 3 val 0xDEAD -> next cycle busy 0, val 0xDEAD
- Issue x5 tag 3, then issue x5 tag 7, then commit x5 tag 3 val 0x11 -> val 0x11, busy 1, tag 7. Commit tag 7 val 0x22 -> busy 0, val 0x22
- Same cycle: issue x6 tag 9 and commit x6 tag 2 val 0x55 (x6 pending on tag 2) -> val 0x55, busy 1, tag 9
- x1..x4 busy, clear asserted with commit x2 val 0x77 and issue x8 tag 5 -> next cycle all busy 0, x2 val 0x77, x8 not busy. rdy low during clear -> no change
- x7 busy tag 4, read x7 while committing x7 tag 4 val 0x99 -> with RF_COMMIT_BYPASS_EN: busy 0, val 0x99 in the same cycle. Without it: busy 1, tag 4 that cycle, then val 0x99 the next cycle
